// File: rtl/writebuf_fsm_if.sv
// AXI-stream ingress for the line-buffer write side: one character per beat.
interface writebuf_fsm_if;
  logic tvalid;
  logic tlast;
  logic tready;

  modport master (output tvalid, output tlast, input tready);
  modport slave  (input tvalid, input tlast, output tready);
endinterface

// File: rtl/writebuf_fsm.sv
// Write-side line-buffer controller: streams beats into the current line and
// drops whole frames that find no free line or overrun the line capacity.
module writebuf_fsm #(
  parameter int MAX_CHARS    = 64,
  parameter int LEN_W        = 8,
  parameter int CNT_W        = 16,
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  writebuf_fsm_if.slave    axis,
  input  logic             fullflag,
  output logic             wr_en,
  output logic             wr_char_incr,
  output logic             wr_newline,
  output logic             wr_rewind,
  output logic             busy,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LAST_POS = LEN_W'(MAX_CHARS - 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             rdy, beat;
  logic             frm_inc, drop_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // Strobes are combinational so each beat is written in the cycle it is accepted.
  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    rdy          = 1'b0;
    wr_en        = 1'b0;
    wr_char_incr = 1'b0;
    wr_newline   = 1'b0;
    wr_rewind    = 1'b0;
    frm_inc      = 1'b0;
    drop_inc     = 1'b0;
    beat         = 1'b0;
    case (state)
      IDLE: begin
        rdy  = rst && (DROP_ON_FULL || !fullflag);
        beat = axis.tvalid && rdy;
        if (beat) begin
          if (fullflag) begin
            // Only reachable in drop mode: the frame is swallowed without strobes.
            if (axis.tlast) drop_inc  = 1'b1;
            else            state_nxt = DROP;
          end else begin
            wr_en = 1'b1;
            if (axis.tlast) begin
              wr_newline = 1'b1;
              frm_inc    = 1'b1;
            end else begin
              wr_char_incr = 1'b1;
              len_nxt      = LEN_W'(1);
              state_nxt    = WRITE;
            end
          end
        end
      end
      WRITE: begin
        rdy  = 1'b1;
        beat = axis.tvalid;
        if (beat) begin
          if (axis.tlast) begin
            wr_en      = 1'b1;
            wr_newline = 1'b1;
            frm_inc    = 1'b1;
            len_nxt    = '0;
            state_nxt  = IDLE;
          end else if (len < LAST_POS) begin
            wr_en        = 1'b1;
            wr_char_incr = 1'b1;
            len_nxt      = len + LEN_W'(1);
          end else begin
            // Line is full and the frame keeps going: discard the partial line.
            wr_rewind = 1'b1;
            len_nxt   = '0;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        rdy  = 1'b1;
        beat = axis.tvalid;
        if (beat && axis.tlast) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        len_nxt   = '0;
      end
    endcase
  end

  assign axis.tready = rdy;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (frm_inc && (frm_cnt != '1))   frm_cnt  <= frm_cnt + CNT_W'(1);
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writebuf_fsm.sv
// Two configurations (drop-on-full and backpressure) driven by one stimulus
// stream and checked against a frame-level model of beats, commits and drops.
module tb_writebuf_fsm;

  localparam int MC   [2] = '{4, 3};
  localparam bit DOF  [2] = '{1'b1, 1'b0};
  localparam int CMAX [2] = '{65535, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fullflag = 1'b0;
  always #5 clk = ~clk;

  writebuf_fsm_if ifa ();
  writebuf_fsm_if ifb ();

  logic        we0, inc0, nl0, rw0, bsy0;
  logic        we1, inc1, nl1, rw1, bsy1;
  logic [15:0] frm0, drp0;
  logic [1:0]  frm1, drp1;

  writebuf_fsm #(.MAX_CHARS(4), .LEN_W(8), .CNT_W(16), .DROP_ON_FULL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .axis(ifa.slave), .fullflag(fullflag),
    .wr_en(we0), .wr_char_incr(inc0), .wr_newline(nl0), .wr_rewind(rw0),
    .busy(bsy0), .frm_cnt(frm0), .drop_cnt(drp0));

  writebuf_fsm #(.MAX_CHARS(3), .LEN_W(2), .CNT_W(2), .DROP_ON_FULL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .axis(ifb.slave), .fullflag(fullflag),
    .wr_en(we1), .wr_char_incr(inc1), .wr_newline(nl1), .wr_rewind(rw1),
    .busy(bsy1), .frm_cnt(frm1), .drop_cnt(drp1));

  logic [5:0]  go [2];
  logic [31:0] gf [2];
  logic [31:0] gd [2];
  assign go[0] = {ifa.tready, we0, inc0, nl0, rw0, bsy0};
  assign go[1] = {ifb.tready, we1, inc1, nl1, rw1, bsy1};
  assign gf[0] = {16'b0, frm0};
  assign gd[0] = {16'b0, drp0};
  assign gf[1] = {30'b0, frm1};
  assign gd[1] = {30'b0, drp1};

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference: in_frame, dropping, beats taken so far, counters.
  bit infr [2];
  bit drp  [2];
  int blen [2];
  int fc   [2];
  int dc   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int i, input logic v, l, f, r,
                       output logic [5:0] eo, output int ef, output int ed);
    logic tr, we, inc, nl, rw, bsy;
    int k;
    {tr, we, inc, nl, rw, bsy} = '0;
    if (!r) begin
      infr[i] = 0; drp[i] = 0; blen[i] = 0; fc[i] = 0; dc[i] = 0;
      ef = 0; ed = 0;
    end else begin
      ef  = fc[i];
      ed  = dc[i];
      bsy = infr[i];
      tr  = infr[i] || DOF[i] || !f;
      if (v && tr) begin
        if (!infr[i]) begin
          if (f) begin
            if (l) begin if (dc[i] < CMAX[i]) dc[i]++; end
            else begin infr[i] = 1; drp[i] = 1; end
          end else begin
            we = 1;
            blen[i] = 1;
            if (l) begin nl = 1; if (fc[i] < CMAX[i]) fc[i]++; end
            else begin inc = 1; infr[i] = 1; drp[i] = 0; end
          end
        end else if (drp[i]) begin
          if (l) begin infr[i] = 0; if (dc[i] < CMAX[i]) dc[i]++; end
        end else begin
          k = blen[i] + 1;
          if (l) begin
            we = 1; nl = 1; infr[i] = 0;
            if (fc[i] < CMAX[i]) fc[i]++;
          end else if (k < MC[i]) begin
            we = 1; inc = 1; blen[i] = k;
          end else begin
            rw = 1; drp[i] = 1;
          end
        end
      end
    end
    eo = {tr, we, inc, nl, rw, bsy};
  endtask

  task automatic check_all(input logic v, l, f);
    logic [5:0] eo;
    int ef, ed;
    for (int i = 0; i < 2; i++) begin
      model(i, v, l, f, rst, eo, ef, ed);
      chk($sformatf("outs%0d", i), 32'(go[i]), 32'(eo));
      chk($sformatf("frm%0d", i), gf[i], 32'(ef));
      chk($sformatf("drop%0d", i), gd[i], 32'(ed));
    end
  endtask

  task automatic cyc(input logic v, l, f);
    @(posedge clk);
    #1;
    ifa.tvalid = v; ifa.tlast = l;
    ifb.tvalid = v; ifb.tlast = l;
    fullflag   = f;
    @(negedge clk);
    check_all(v, l, f);
  endtask

  task automatic frame(input int n, input logic f);
    for (int b = 1; b <= n; b++) cyc(1'b1, b == n, f);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    ifa.tvalid = 1'b1; ifb.tvalid = 1'b1;
    ifa.tlast  = 1'b0; ifb.tlast  = 1'b0;
    rst = 1'b0;
    #1;
    check_all(1'b1, 1'b0, fullflag);
    ifa.tvalid = 1'b0; ifb.tvalid = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    ifa.tvalid = 1'b0; ifa.tlast = 1'b0;
    ifb.tvalid = 1'b0; ifb.tlast = 1'b0;
    #12;
    check_all(1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;

    frame(5, 1'b0);
    frame(1, 1'b0);
    frame(4, 1'b0);
    frame(3, 1'b0);
    frame(6, 1'b0);
    frame(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    // gaps and fullflag toggling while a line is owned
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    mid_reset();
    cyc(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) frame(2, 1'b0);
    frame(7, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) mid_reset();
      else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
